// File: rtl/dice_roll_monitor.sv
// Receiving end of the electronic dice: detects the end of each roll, rejects short presses,
// validates the settled face value and publishes it with strobes, a roll counter and a 7-segment digit.
module dice_roll_monitor #(
    parameter int MIN_HOLD = 4,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    output logic [2:0]         result,
    output logic               result_valid,
    output logic               err,
    output logic               short_press,
    output logic               double,
    output logic [COUNT_W-1:0] roll_count,
    output logic [6:0]         seg
);

    localparam int HOLD_W = (MIN_HOLD <= 1) ? 1 : $clog2(MIN_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [2:0]          result_q;
    logic                has_prev_q;
    logic [COUNT_W-1:0]  roll_count_q;
    logic [6:0]          seg_q;
    logic                result_valid_q;
    logic                err_q;
    logic                short_press_q;
    logic                double_q;

    logic [HOLD_W-1:0]   hold_cnt_d;
    logic [COUNT_W-1:0]  roll_count_d;
    logic [6:0]          seg_d;
    logic                throw_ok;
    logic                hold_met;

    function automatic logic [6:0] seg_encode(input logic [2:0] v);
        case (v)
            3'd1:    return 7'h06;
            3'd2:    return 7'h5B;
            3'd3:    return 7'h4F;
            3'd4:    return 7'h66;
            3'd5:    return 7'h6D;
            3'd6:    return 7'h7D;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    function automatic logic [HOLD_W-1:0] sat_inc_hold(input logic [HOLD_W-1:0] v);
        return (v >= HOLD_W'(MIN_HOLD)) ? v : v + HOLD_W'(1);
    endfunction

    always_comb begin
        hold_cnt_d   = sat_inc_hold(hold_cnt_q);
        roll_count_d = sat_inc_count(roll_count_q);
        seg_d        = seg_encode(throw);
        throw_ok     = (throw != 3'd0) && (throw != 3'd7);
        hold_met     = (hold_cnt_q >= HOLD_W'(MIN_HOLD));
    end

    // SETTLE is a one-cycle gap after release so the dice can register its final face.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            hold_cnt_q     <= '0;
            result_q       <= 3'd0;
            has_prev_q     <= 1'b0;
            roll_count_q   <= '0;
            seg_q          <= 7'h00;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            short_press_q  <= 1'b0;
            double_q       <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            short_press_q  <= 1'b0;
            double_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (button) begin
                        hold_cnt_q <= HOLD_W'(1);
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (button) begin
                        hold_cnt_q <= hold_cnt_d;
                    end else if (hold_met) begin
                        state_q <= SETTLE;
                    end else begin
                        short_press_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                SETTLE: begin
                    state_q <= IDLE;
                    if (throw_ok) begin
                        result_q       <= throw;
                        seg_q          <= seg_d;
                        result_valid_q <= 1'b1;
                        roll_count_q   <= roll_count_d;
                        double_q       <= has_prev_q && (throw == result_q);
                        has_prev_q     <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign short_press  = short_press_q;
    assign double       = double_q;
    assign roll_count   = roll_count_q;
    assign seg          = seg_q;

endmodule

// File: tb/tb_dice_roll_monitor.sv
// Directed bench for dice_roll_monitor: a default instance plus a 2-bit-counter instance for saturation.
module tb_dice_roll_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_sat = 1'b0;
    logic       button = 1'b0;
    logic [2:0] throw = 3'd0;

    logic [2:0] result;
    logic       result_valid, err, short_press, double;
    logic [7:0] roll_count;
    logic [6:0] seg;

    logic [2:0] s_result;
    logic       s_result_valid, s_err, s_short_press, s_double;
    logic [1:0] s_roll_count;
    logic [6:0] s_seg;

    int n_chk = 0;
    int n_fail = 0;

    dice_roll_monitor #(.MIN_HOLD(4), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .button(button), .throw(throw),
        .result(result), .result_valid(result_valid), .err(err),
        .short_press(short_press), .double(double),
        .roll_count(roll_count), .seg(seg)
    );

    dice_roll_monitor #(.MIN_HOLD(4), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst(rst_sat), .button(button), .throw(throw),
        .result(s_result), .result_valid(s_result_valid), .err(s_err),
        .short_press(s_short_press), .double(s_double),
        .roll_count(s_roll_count), .seg(s_seg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Hold button for n sampled edges, release with throw=t, return just after E0.
    task automatic roll(input int n, input logic [2:0] t);
        @(negedge clk); button = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk); button = 1'b0; throw = t;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; button = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (result !== 3'd0) begin n_fail++; $display("FAIL rst_result: got %0d want 0", result); end
        n_chk++; if (seg !== 7'h00) begin n_fail++; $display("FAIL rst_seg: got %h want 00", seg); end
        n_chk++; if (roll_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", roll_count); end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({result_valid, err, short_press, double} !== 4'b0000) begin
                n_fail++; $display("FAIL idle_strobes: got %b want 0000", {result_valid, err, short_press, double});
            end
        end
        n_chk++; if (result !== 3'd0) begin n_fail++; $display("FAIL idle_result: got %0d want 0", result); end
        n_chk++; if (seg !== 7'h00) begin n_fail++; $display("FAIL idle_seg: got %h want 00", seg); end
    endtask

    task automatic test_valid_roll;
        roll(10, 3'd5);
        n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL vr_early_valid: got %b want 0", result_valid); end
        @(posedge clk); #1;
        n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL vr_valid: got %b want 1", result_valid); end
        n_chk++; if (result !== 3'd5) begin n_fail++; $display("FAIL vr_result: got %0d want 5", result); end
        n_chk++; if (seg !== 7'h6D) begin n_fail++; $display("FAIL vr_seg: got %h want 6d", seg); end
        n_chk++; if (roll_count !== 8'd1) begin n_fail++; $display("FAIL vr_count: got %0d want 1", roll_count); end
        n_chk++; if ({double, err, short_press} !== 3'b000) begin n_fail++; $display("FAIL vr_other: got %b want 000", {double, err, short_press}); end
        @(posedge clk); #1;
        n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL vr_drop: got %b want 0", result_valid); end
        n_chk++; if (result !== 3'd5) begin n_fail++; $display("FAIL vr_hold: got %0d want 5", result); end
    endtask

    task automatic test_double;
        logic [2:0] vals [3];
        logic       dbl [3];
        logic [6:0] segs [3];
        vals = '{3'd3, 3'd3, 3'd4};
        dbl  = '{1'b0, 1'b1, 1'b0};
        segs = '{7'h4F, 7'h4F, 7'h66};
        for (int i = 0; i < 3; i++) begin
            roll(6, vals[i]);
            @(posedge clk); #1;
            n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL dbl_valid[%0d]: got %b want 1", i, result_valid); end
            n_chk++; if (double !== dbl[i]) begin n_fail++; $display("FAIL dbl_flag[%0d]: got %b want %b", i, double, dbl[i]); end
            n_chk++; if (roll_count !== 8'(i + 2)) begin n_fail++; $display("FAIL dbl_count[%0d]: got %0d want %0d", i, roll_count, i + 2); end
            n_chk++; if (seg !== segs[i]) begin n_fail++; $display("FAIL dbl_seg[%0d]: got %h want %h", i, seg, segs[i]); end
        end
    endtask

    task automatic test_short_press;
        roll(3, 3'd2);
        n_chk++; if (short_press !== 1'b1) begin n_fail++; $display("FAIL sp_pulse: got %b want 1", short_press); end
        n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL sp_novalid0: got %b want 0", result_valid); end
        @(posedge clk); #1;
        n_chk++; if (short_press !== 1'b0) begin n_fail++; $display("FAIL sp_drop: got %b want 0", short_press); end
        n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL sp_novalid1: got %b want 0", result_valid); end
        n_chk++; if (result !== 3'd4) begin n_fail++; $display("FAIL sp_result: got %0d want 4", result); end
        n_chk++; if (roll_count !== 8'd4) begin n_fail++; $display("FAIL sp_count: got %0d want 4", roll_count); end
        roll(4, 3'd2);
        n_chk++; if (short_press !== 1'b0) begin n_fail++; $display("FAIL sp4_short: got %b want 0", short_press); end
        @(posedge clk); #1;
        n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL sp4_valid: got %b want 1", result_valid); end
        n_chk++; if (result !== 3'd2) begin n_fail++; $display("FAIL sp4_result: got %0d want 2", result); end
        n_chk++; if (seg !== 7'h5B) begin n_fail++; $display("FAIL sp4_seg: got %h want 5b", seg); end
        n_chk++; if (roll_count !== 8'd5) begin n_fail++; $display("FAIL sp4_count: got %0d want 5", roll_count); end
    endtask

    task automatic test_invalid;
        logic [2:0] bad [2];
        bad = '{3'd7, 3'd0};
        for (int i = 0; i < 2; i++) begin
            roll(5, bad[i]);
            @(posedge clk); #1;
            n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err[%0d]: got %b want 1", i, err); end
            n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid[%0d]: got %b want 0", i, result_valid); end
            n_chk++; if (result !== 3'd2) begin n_fail++; $display("FAIL inv_result[%0d]: got %0d want 2", i, result); end
            n_chk++; if (roll_count !== 8'd5) begin n_fail++; $display("FAIL inv_count[%0d]: got %0d want 5", i, roll_count); end
            n_chk++; if (seg !== 7'h5B) begin n_fail++; $display("FAIL inv_seg[%0d]: got %h want 5b", i, seg); end
            @(posedge clk); #1;
            n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL inv_drop[%0d]: got %b want 0", i, err); end
        end
        // previous accepted value is still 2, so a following 2 must flag double
        roll(5, 3'd2);
        @(posedge clk); #1;
        n_chk++; if (double !== 1'b1) begin n_fail++; $display("FAIL inv_then_double: got %b want 1", double); end
        n_chk++; if (roll_count !== 8'd6) begin n_fail++; $display("FAIL inv_then_count: got %0d want 6", roll_count); end
    endtask

    task automatic test_back_to_back;
        roll(4, 3'd6);
        @(negedge clk); button = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", result_valid); end
        n_chk++; if (result !== 3'd6) begin n_fail++; $display("FAIL b2b_result: got %0d want 6", result); end
        n_chk++; if (roll_count !== 8'd7) begin n_fail++; $display("FAIL b2b_count: got %0d want 7", roll_count); end
        repeat (3) @(posedge clk);
        @(negedge clk); button = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (short_press !== 1'b1) begin n_fail++; $display("FAIL b2b_short: got %b want 1", short_press); end
        @(posedge clk); #1;
        n_chk++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_novalid: got %b want 0", result_valid); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); button = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); #2; rst = 1'b0; #1;
        n_chk++; if (result !== 3'd0) begin n_fail++; $display("FAIL rm_result: got %0d want 0", result); end
        n_chk++; if (roll_count !== 8'd0) begin n_fail++; $display("FAIL rm_count: got %0d want 0", roll_count); end
        n_chk++; if (seg !== 7'h00) begin n_fail++; $display("FAIL rm_seg: got %h want 00", seg); end
        button = 1'b0; throw = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk); button = 1'b1; rst = 1'b1;
        n_chk++; if ({result_valid, err, short_press, double} !== 4'b0000) begin n_fail++; $display("FAIL rm_strobes: got %b want 0000", {result_valid, err, short_press, double}); end
        repeat (4) @(posedge clk);
        @(negedge clk); button = 1'b0; throw = 3'd1;
        @(posedge clk); #1;
        n_chk++; if (short_press !== 1'b0) begin n_fail++; $display("FAIL rm_newpress_short: got %b want 0", short_press); end
        @(posedge clk); #1;
        n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL rm_newpress_valid: got %b want 1", result_valid); end
        n_chk++; if (seg !== 7'h06) begin n_fail++; $display("FAIL rm_newpress_seg: got %h want 06", seg); end
        n_chk++; if (roll_count !== 8'd1) begin n_fail++; $display("FAIL rm_newpress_count: got %0d want 1", roll_count); end
    endtask

    task automatic test_saturation;
        logic [2:0] vals [5];
        logic       dbl [5];
        logic [1:0] cnt [5];
        vals = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd5};
        dbl  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk); rst_sat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            roll(4, vals[i]);
            @(posedge clk); #1;
            n_chk++; if (s_result_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid[%0d]: got %b want 1", i, s_result_valid); end
            n_chk++; if (s_roll_count !== cnt[i]) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, s_roll_count, cnt[i]); end
            n_chk++; if (s_double !== dbl[i]) begin n_fail++; $display("FAIL sat_double[%0d]: got %b want %b", i, s_double, dbl[i]); end
            n_chk++; if (s_result !== vals[i]) begin n_fail++; $display("FAIL sat_result[%0d]: got %0d want %0d", i, s_result, vals[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_valid_roll();
        test_double();
        test_short_press();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_roll_monitor.md
# dice_roll_monitor

Receiving end of the electronic dice: watches the same `button` that drives the dice and the dice's `throw` output. It detects the end of each roll, rejects presses that were too short, and validates the settled face value. It then publishes the accepted result with a one-cycle strobe, flags repeated values, counts rolls, and drives a 7-segment digit for the board display.

## Interface
Parameters:
- `MIN_HOLD`, default 4: minimum number of clock edges `button` must be sampled high for a roll to count (≥1).
- `COUNT_W`, default 8: width of the roll counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `button`  in  1  roll button, the same signal fed to the dice; already synchronous to `clk`.
- `throw`  in  3  dice face value; legal values are 1..6.
- `result`  out  3  last accepted face value.
- `result_valid`  out  1  one-cycle strobe when `result` is updated.
- `err`  out  1  one-cycle strobe when the settled `throw` is 0 or 7.
- `short_press`  out  1  one-cycle strobe when a press is rejected as shorter than `MIN_HOLD`.
- `double`  out  1  one-cycle strobe, coincident with `result_valid`, when the new result equals the previous accepted result.
- `roll_count`  out  COUNT_W  number of accepted rolls, saturating.
- `seg`  out  7  7-segment pattern for `result`, bit order gfedcba, active high.

## Operation
- All outputs are registered.
- Reset values, applied asynchronously while `rst`=0:
  - state=IDLE, `hold_cnt`=0
  - `result`=0, `has_prev`=0
  - `roll_count`=0, `seg`=7'h00
  - all strobes 0
- States:
  - IDLE: if `button`=1, set `hold_cnt`=1 and go to HOLD; otherwise stay.
  - HOLD: if `button`=1, increment `hold_cnt`, saturating at `MIN_HOLD`.
    - If `button`=0 and `hold_cnt`≥`MIN_HOLD`, go to SETTLE.
    - If `button`=0 and `hold_cnt`<`MIN_HOLD`, pulse `short_press` and go to IDLE.
  - SETTLE: sample `throw` and always go to IDLE; `button` is ignored in this state.
    - If `throw` is 1..6:
      - `result`←`throw`, pulse `result_valid`.
      - Increment `roll_count` unless it is all ones.
      - Pulse `double` if `has_prev`=1 and `throw`==`result`.
      - Set `has_prev`←1.
    - If `throw` is 0 or 7: pulse `err`; `result`, `roll_count` and `has_prev` are unchanged.
- `seg` is updated on the same edge as `result`, from the new value:
  - 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D (hex).
  - `result`=0 → 00 (blank).
- Strobes are mutually exclusive per cycle, except that `double` always accompanies `result_valid`.

## Timing
- Let edge E0 be the first edge at which `button` is sampled 0 in HOLD.
  - SETTLE is entered after E0.
  - `throw` is sampled at E1.
  - `result`, `seg`, `roll_count` and the strobes are visible from E1 to E2; the strobes drop at E2.
- The gap between E0 and E1 gives the dice one cycle to register its final value after release.
- `short_press` is visible from E0 to E1.
- Earliest new roll:
  - A press still high at E1 is ignored.
  - IDLE can first see `button`=1 at E2.
  - A press that stays high from E1 onwards is detected at E2, with `hold_cnt` starting at 1.
- Exact boundary: with `MIN_HOLD`=4, a press sampled high at exactly 4 edges is accepted; 3 edges gives `short_press`.
- `roll_count` saturation: at all ones it holds; `result_valid` and `double` still pulse.
- Reset mid-roll, in any state:
  - All state is cleared immediately, and no strobe is emitted for the aborted roll.
  - After release, a `button` already high is treated as a new press starting at the first edge where `rst`=1.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles, then `rst`=1 with `button`=0 for 10 cycles → `result`=0, `seg`=00, `roll_count`=0, no strobes.
- Valid roll: `button` high for 10 edges, `throw`=5 at release → exactly 2 edges after the release edge, `result_valid`=1 for 1 cycle, `result`=5, `seg`=6D, `roll_count`=1, `double`=0.
- Double: accepted roll of 3, then a second accepted roll of 3 → second `result_valid` accompanied by `double`=1, `roll_count`=2. A third roll of 4 → `double`=0.
- Short press, `MIN_HOLD`=4:
  - 3-edge press → `short_press` pulses 1 edge after release; `result` and `roll_count` unchanged.
  - 4-edge press → accepted.
- Invalid value: accepted-length press with `throw`=7, then another with `throw`=0 → `err` pulses each time; `result` and `roll_count` unchanged; `result_valid`=0.
- Reset and saturation:
  - Assert `rst` during HOLD → no strobes; all outputs return to reset values asynchronously.
  - With `COUNT_W`=2, 5 valid rolls → `roll_count` stops at 3 while `result_valid` still pulses 5 times.
